// File: rtl/imem_sync_pkg.sv
// Shared definitions for the synchronous instruction memory.
//   INST_BUS_LENGTH  : instruction word width
//   INST_ADDR_LENGTH : fetch / boot-load word address width
//   IMEM_NOP         : word returned for out-of-range fetches
//   imem_state_e     : controller states (boot-load, fetch, drain before reload)
package imem_sync_pkg;

    localparam int unsigned INST_BUS_LENGTH  = 16;
    localparam int unsigned INST_ADDR_LENGTH = 8;

    localparam logic [INST_BUS_LENGTH-1:0] IMEM_NOP = 16'h0000;

    typedef enum logic [1:0] {
        IMEM_BOOT  = 2'd0,
        IMEM_RUN   = 2'd1,
        IMEM_DRAIN = 2'd2
    } imem_state_e;

    // True when a word address falls inside the implemented array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/imem_ram_sp.sv
// Single-port synchronous RAM with registered read.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (read register only; array is never cleared)
//   en_i     : port enable (read when we_i=0, write when we_i=1)
//   we_i     : write enable
//   addr_i   : word address, must be < DEPTH when en_i=1
//   wdata_i  : write data
//   rdata_o  : read data, valid the cycle after a read, held until the next read
module imem_ram_sp
    import imem_sync_pkg::*;
#(
    parameter int unsigned DATA_W = INST_BUS_LENGTH,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory with boot-load port and valid/ready fetch interface.
// Ports:
//   clk_i, rst_i        : clock (rising edge), asynchronous active-high reset
//   ld_valid_i/addr/data: boot-load write strobe, word address, word (BOOT only)
//   ld_done_i           : leave BOOT and start serving fetches
//   reload_i            : return to BOOT once in-flight responses are gone
//   ld_count_o          : words accepted since entering BOOT (saturating)
//   running_o           : high while serving fetches
//   req_valid_i/ready_o : fetch request handshake, PC_i is the word address
//   flush_i             : drop every in-flight and held response
//   resp_valid_o/ready_i: response handshake, inst_o/err_o held while stalled
//   err_o               : response came from an address >= DEPTH (inst_o = NOP_WORD)
module imem_sync
    import imem_sync_pkg::*;
#(
    parameter int unsigned      DATA_W   = INST_BUS_LENGTH,
    parameter int unsigned      ADDR_W   = INST_ADDR_LENGTH,
    parameter int unsigned      DEPTH    = 256,
    parameter int unsigned      RD_LAT   = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_done_i,
    input  logic              reload_i,
    output logic [ADDR_W:0]   ld_count_o,
    output logic              running_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] PC_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              err_o
);

    localparam int unsigned RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Total transactions allowed in flight, including the one presented at the output.
    localparam int unsigned MAX_OCC = RD_LAT + 1;
    localparam int unsigned OCC_W   = $clog2(MAX_OCC + 1);
    // The hold FIFO must absorb everything in flight if the consumer stalls.
    localparam int unsigned FIFO_D  = MAX_OCC;
    localparam int unsigned PTR_W   = $clog2(FIFO_D);
    localparam int unsigned CNT_W   = $clog2(FIFO_D + 1);

    imem_state_e state_q, state_d;
    logic [ADDR_W:0] ld_count_q, ld_count_d;
    logic [OCC_W-1:0] occ_q, occ_d, occ_after;

    logic accept, consume, go_boot, kill;
    logic pc_ok, ld_ok, ld_we, rd_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    logic s1_v_q, s1_err_q;
    logic [DATA_W-1:0] s1_data;

    logic last_v, last_err;
    logic [DATA_W-1:0] last_data;

    logic [DATA_W-1:0] fifo_data_q [FIFO_D];
    logic              fifo_err_q  [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshakes and memory port
    // ------------------------------------------------------------------
    // When occupancy is at its limit the oldest entry is necessarily at the output,
    // so resp_ready_i alone tells whether a slot frees up this cycle.
    assign req_ready_o = (state_q == IMEM_RUN) &&
                         ((occ_q != OCC_W'(MAX_OCC)) || resp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign consume     = resp_valid_o && resp_ready_i;

    assign pc_ok = addr_in_range(32'(PC_i), DEPTH);
    assign ld_ok = addr_in_range(32'(ld_addr_i), DEPTH);

    // Loads and fetches never overlap: loads only in BOOT, fetches only in RUN.
    assign ld_we    = (state_q == IMEM_BOOT) && ld_valid_i && ld_ok;
    assign rd_en    = accept && pc_ok;
    assign ram_addr = ld_we ? ld_addr_i[RAM_AW-1:0] : PC_i[RAM_AW-1:0];

    imem_ram_sp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (ld_we || rd_en),
        .we_i    (ld_we),
        .addr_i  (ram_addr),
        .wdata_i (ld_data_i),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    assign occ_after = flush_i ? '0 : occ_q - OCC_W'(consume);

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        go_boot    = 1'b0;
        unique case (state_q)
            IMEM_BOOT: begin
                // Dropped out-of-range writes still count; saturate at 2**ADDR_W.
                if (ld_valid_i && !ld_count_q[ADDR_W]) begin
                    ld_count_d = ld_count_q + (ADDR_W + 1)'(1);
                end
                if (ld_done_i) begin
                    state_d = IMEM_RUN;
                end
            end
            IMEM_RUN: begin
                if (reload_i) begin
                    if ((occ_q == '0) || flush_i) begin
                        go_boot = 1'b1;
                        state_d = IMEM_BOOT;
                    end else begin
                        state_d = IMEM_DRAIN;
                    end
                end
            end
            IMEM_DRAIN: begin
                if (occ_after == '0) begin
                    go_boot = 1'b1;
                    state_d = IMEM_BOOT;
                end
            end
            default: state_d = IMEM_BOOT;
        endcase
        if (go_boot) begin
            ld_count_d = '0;
        end
        occ_d = go_boot ? '0 : occ_after + OCC_W'(accept);
    end

    // Entering BOOT discards the pipeline just like a flush.
    assign kill = flush_i || go_boot;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IMEM_BOOT;
            ld_count_q <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            occ_q      <= occ_d;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 1 is the RAM read register, optional stage 2
    // ------------------------------------------------------------------
    // A request accepted together with flush_i survives; only older entries die.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q   <= 1'b0;
            s1_err_q <= 1'b0;
        end else begin
            s1_v_q <= accept && !go_boot;
            if (accept) begin
                s1_err_q <= !pc_ok;
            end
        end
    end

    assign s1_data = s1_err_q ? NOP_WORD : ram_rdata;

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_v_q, s2_err_q;
        logic [DATA_W-1:0] s2_data_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s2_v_q    <= 1'b0;
                s2_err_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_v_q <= s1_v_q && !kill;
                if (s1_v_q) begin
                    s2_err_q  <= s1_err_q;
                    s2_data_q <= s1_data;
                end
            end
        end

        assign last_v    = s2_v_q;
        assign last_err  = s2_err_q;
        assign last_data = s2_data_q;
    end else begin : g_lat1
        assign last_v    = s1_v_q;
        assign last_err  = s1_err_q;
        assign last_data = s1_data;
    end

    // ------------------------------------------------------------------
    // Output hold FIFO. The last pipeline stage is presented directly when
    // the FIFO is empty; if it is not taken that cycle it moves into the
    // FIFO, so the presented word never changes while stalled.
    // ------------------------------------------------------------------
    assign push = last_v && !kill && !((cnt_q == '0) && resp_ready_i);
    assign pop  = (cnt_q != '0) && resp_ready_i && !kill;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (kill) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= last_data;
            fifo_err_q[wr_ptr_q]  <= last_err;
        end
    end

    assign resp_valid_o = (cnt_q != '0) || last_v;
    assign inst_o       = (cnt_q != '0) ? fifo_data_q[rd_ptr_q] : last_data;
    assign err_o        = (cnt_q != '0) ? fifo_err_q[rd_ptr_q]  : last_err;

    assign ld_count_o = ld_count_q;
    assign running_o  = (state_q == IMEM_RUN);

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_done = 1'b0;
    logic              reload = 1'b0;
    logic [ADDR_W:0]   ld_count;
    logic              running;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] pc = '0;
    logic              flush = 1'b0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] inst;
    logic              err;

    always #5 clk = ~clk;

    imem_sync #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ld_valid_i   (ld_valid),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .ld_done_i    (ld_done),
        .reload_i     (reload),
        .ld_count_o   (ld_count),
        .running_o    (running),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .PC_i         (pc),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .inst_o       (inst),
        .err_o        (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: memory image, mode, load count and an ordered list of
    // outstanding fetches stamped with their accept cycle.
    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mmem [DEPTH];
    int          mstate = 0;  // 0 boot, 1 run, 2 drain
    int          mcount = 0;
    int          cyc    = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] inst;
        logic        err;
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, then advance the model over the edge.
    task automatic tick();
        bit   ev, er, pre_empty;
        int   st;
        exp_t e;
        @(negedge clk);
        #1;
        ev = (q.size() > 0) && (cyc - q[0].cyc >= RD_LAT);
        er = (mstate == 1) && ((q.size() < RD_LAT + 1) || resp_ready);
        chk("running", 32'(running), 32'(mstate == 1));
        chk("ld_count", 32'(ld_count), 32'(mcount));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        chk("req_ready", 32'(req_ready), 32'(er));
        if (ev) begin
            chk("inst", 32'(inst), 32'(q[0].data));
            chk("err", 32'(err), 32'(q[0].err));
        end
        if (!rst) begin
            st = mstate;
            if (st == 0) begin
                if (ld_valid) begin
                    if (ld_addr < DEPTH) mmem[ld_addr[4:0]] = ld_data;
                    if (mcount < 256) mcount++;
                end
                if (ld_done) mstate = 1;
            end else begin
                pre_empty = (q.size() == 0);
                if (flush) q.delete();
                else if (ev && resp_ready) void'(q.pop_front());
                if (req_valid && er) begin
                    e.err  = (pc >= DEPTH);
                    e.data = e.err ? 16'h0000 : mmem[pc[4:0]];
                    e.cyc  = cyc;
                    q.push_back(e);
                end
                if (st == 1 && reload) begin
                    if (pre_empty || flush) begin
                        mstate = 0;
                        mcount = 0;
                        q.delete();
                    end else begin
                        mstate = 2;
                    end
                end else if (st == 2 && q.size() == 0) begin
                    mstate = 0;
                    mcount = 0;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d, input logic done);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = done;
        tick();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, output logic [15:0] d, output logic e,
                         output int lat);
        req_valid  = 1'b1;
        pc         = a;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        d = inst;
        e = err;
        tick();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset running", 32'(running), 32'd0);
        chk("reset ld_count", 32'(ld_count), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        q.delete();
        mstate = 0;
        mcount = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        logic        e;
        int          lat;
        int          nval;
        int          first;
        int          lastv;

        tab[0] = '{pc: 8'd0,   inst: 16'h8800, err: 1'b0};
        tab[1] = '{pc: 8'd1,   inst: 16'h8901, err: 1'b0};
        tab[2] = '{pc: 8'd40,  inst: 16'h0000, err: 1'b1};
        tab[3] = '{pc: 8'd1,   inst: 16'h8901, err: 1'b0};
        tab[4] = '{pc: 8'd255, inst: 16'h0000, err: 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset inst", 32'(inst), 32'd0);
        chk("reset ld_count", 32'(ld_count), 32'd0);
        chk("reset running", 32'(running), 32'd0);
        rst = 1'b0;
        tick();

        // Boot A: two words, then start
        load(8'd0, 16'h8800, 1'b0);
        load(8'd1, 16'h8901, 1'b0);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        chk("boot ld_count", 32'(ld_count), 32'd2);
        chk("boot running", 32'(running), 32'd1);

        // Load strobe in RUN must not write
        load(8'd0, 16'h1234, 1'b0);

        for (int i = 0; i < 5; i++) begin
            fetch(tab[i].pc, d, e, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(RD_LAT));
            chk($sformatf("vec%0d inst", i), 32'(d), 32'(tab[i].inst));
            chk($sformatf("vec%0d err", i), 32'(e), 32'(tab[i].err));
        end

        // Reload with one held response: DRAIN until consumed, then BOOT
        req_valid  = 1'b1;
        pc         = 8'd1;
        resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("drain running", 32'(running), 32'd0);
        chk("drain req_ready", 32'(req_ready), 32'd0);
        chk("drain held inst", 32'(inst), 32'h8901);
        tick();
        tick();
        resp_ready = 1'b1;
        tick();
        chk("reboot ld_count", 32'(ld_count), 32'd0);
        chk("reboot running", 32'(running), 32'd0);

        // Boot B: full image, a dropped out-of-range write, load+done together
        load(8'd0, 16'h8800, 1'b0);
        load(8'd1, 16'h8901, 1'b0);
        for (int a = 2; a < DEPTH; a++) load(8'(a), 16'($urandom), 1'b0);
        load(8'd40, 16'hffff, 1'b0);
        load(8'd2, 16'hb2a2, 1'b1);
        chk("bootB ld_count", 32'(ld_count), 32'(DEPTH + 2));
        chk("bootB running", 32'(running), 32'd1);
        fetch(8'd2, d, e, lat);
        chk("load+done inst", 32'(d), 32'hb2a2);

        // Streaming PC 0..7 back to back
        nval = 0;
        first = -1;
        lastv = -1;
        resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8);
            pc = 8'(k);
            if (resp_valid) begin
                if (first < 0) first = k;
                lastv = k;
                chk("stream data", 32'(inst), 32'(mmem[nval]));
                nval++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("stream count", 32'(nval), 32'd8);
        chk("stream consecutive", 32'(lastv - first), 32'd7);

        // Stall: occupancy reaches RD_LAT+1 and req_ready drops
        resp_ready = 1'b0;
        for (int k = 8; k < 11; k++) begin
            req_valid = 1'b1;
            pc = 8'(k);
            tick();
        end
        chk("stall req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("stall inst stable", 32'(inst), 32'(mmem[8]));
        resp_ready = 1'b1;
        repeat (5) tick();

        // Out of range then in range
        fetch(8'd40, d, e, lat);
        chk("oor inst", 32'(d), 32'h0000);
        chk("oor err", 32'(e), 32'd1);
        fetch(8'd1, d, e, lat);
        chk("after oor inst", 32'(d), 32'h8901);
        chk("after oor err", 32'(e), 32'd0);

        // Flush with two in flight, new PC issued with the flush
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        pc = 8'd3;
        tick();
        pc = 8'd4;
        tick();
        pc = 8'd5;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush resp_valid", 32'(resp_valid), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk("flush first inst", 32'(inst), 32'(mmem[5]));
        chk("flush first err", 32'(err), 32'd0);
        resp_ready = 1'b1;
        tick();

        // Asynchronous reset mid-stream; memory survives
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1;
            pc = 8'(k);
            tick();
        end
        req_valid = 1'b0;
        async_reset();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        fetch(8'd0, d, e, lat);
        chk("post-reset mem0", 32'(d), 32'h8800);
        fetch(8'd2, d, e, lat);
        chk("post-reset mem2", 32'(d), 32'hb2a2);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            pc         = 8'($urandom_range(0, 47));
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            tick();
        end
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (6) tick();

        // Reload from an idle pipeline goes straight to BOOT
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("idle reload running", 32'(running), 32'd0);
        chk("idle reload ld_count", 32'(ld_count), 32'd0);
        load(8'd7, 16'h0707, 1'b0);
        chk("reload boot ld_count", 32'(ld_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
